// File: rtl/drum_pkg.sv
// Shared fixed-point constants, FSM state type and saturating helpers for the
// drum-membrane iteration controller.
package drum_pkg;

    localparam int unsigned DATA_W_DEF = 18;
    localparam int unsigned FRAC_W_DEF = 17;

    localparam int unsigned WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } drum_state_e;

    function automatic wide_t max_pos(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t min_neg(input int unsigned w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

    localparam wide_t ONE     = wide_t'(1) <<< FRAC_W_DEF;
    localparam wide_t MAX_POS = max_pos(DATA_W_DEF);
    localparam wide_t MIN_NEG = min_neg(DATA_W_DEF);

    function automatic wide_t clamp_hi(input wide_t v, input wide_t hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic wide_t clamp_w(input wide_t v, input int unsigned w);
        wide_t r;
        r = v;
        if (v > max_pos(w)) begin
            r = max_pos(w);
        end else if (v < min_neg(w)) begin
            r = min_neg(w);
        end
        return r;
    endfunction

    // Square lands in Q(2).(2*frac); the shift returns it to Q1.frac before clamping.
    function automatic wide_t sat_square(input wide_t a, input int unsigned frac,
                                         input int unsigned w);
        wide_t p;
        p = (a * a) >>> frac;
        return clamp_w(p, w);
    endfunction

endpackage

// File: rtl/signed_mult_q.sv
// Saturating fixed-point square of a Q1.FRAC_W operand; -1.0 squared clamps to
// the largest positive code.
module signed_mult_q
    import drum_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned FRAC_W = FRAC_W_DEF
) (
    input  logic signed [DATA_W-1:0] a_i,
    output logic signed [DATA_W-1:0] sq_o
);

    wide_t sq_wide;

    always_comb begin
        sq_wide = sat_square(wide_t'(a_i), FRAC_W, DATA_W);
        sq_o    = sq_wide[DATA_W-1:0];
    end

endmodule

// File: rtl/drum_iter_ctrl.sv
// Strike sequencer for the drum node grid: load/run control, nonlinear tension
// update, feedback latch pulse, decimated sample stream and decay detection.
module drum_iter_ctrl
    import drum_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned FRAC_W      = FRAC_W_DEF,
    parameter int unsigned RHO_SHIFT   = 5,
    parameter int unsigned LOAD_CYCLES = 4,
    parameter int unsigned SAMPLE_DIV  = 1,
    parameter int unsigned QUIET_ITERS = 256,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     strike,
    input  logic                     nonlin_en,
    input  logic signed [DATA_W-1:0] rho_init,
    input  logic signed [DATA_W-1:0] rho_max,
    input  logic signed [DATA_W-1:0] quiet_thresh,
    input  logic                     iter_done,
    input  logic signed [DATA_W-1:0] center_amp,
    output logic                     grid_reset,
    output logic                     load_hit,
    output logic                     latch_feedback,
    output logic signed [DATA_W-1:0] rho,
    output logic signed [DATA_W-1:0] sample_data,
    output logic                     sample_valid,
    input  logic                     sample_ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         iter_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int unsigned LD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam int unsigned QT_W = $clog2(QUIET_ITERS + 1);
    localparam int unsigned DV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LOAD_CYCLES - 1);
    localparam logic [QT_W-1:0] QT_LIM  = QT_W'(QUIET_ITERS);
    localparam logic [DV_W-1:0] DV_LAST = DV_W'(SAMPLE_DIV - 1);

    localparam logic signed [DATA_W-1:0] D_MAX = DATA_W'(max_pos(DATA_W));
    localparam logic signed [DATA_W-1:0] D_MIN = DATA_W'(min_neg(DATA_W));

    drum_state_e              state_q, state_d;
    logic [LD_W-1:0]          load_cnt_q, load_cnt_d;
    logic [QT_W-1:0]          quiet_q, quiet_d;
    logic [DV_W-1:0]          dec_q, dec_d;
    logic signed [DATA_W-1:0] rho_q, rho_d;
    logic [CNT_W-1:0]         iter_q, iter_d;
    logic [CNT_W-1:0]         drop_q, drop_d;
    logic signed [DATA_W-1:0] data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     latch_q, latch_d;

    logic signed [DATA_W-1:0] sq;
    logic signed [DATA_W-1:0] sq_sh;
    logic signed [DATA_W:0]   cand;
    logic signed [DATA_W-1:0] rho_nl;
    logic signed [DATA_W-1:0] amp_abs;
    logic                     is_quiet;
    logic [QT_W-1:0]          quiet_inc;
    logic                     take;
    wide_t                    rho_clamped;

    signed_mult_q #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_square (
        .a_i  (center_amp),
        .sq_o (sq)
    );

    // sq is never negative, so the one-bit-wider sum cannot wrap before the clamp.
    always_comb begin
        sq_sh       = sq >>> RHO_SHIFT;
        cand        = {rho_init[DATA_W-1], rho_init} + {1'b0, sq_sh};
        rho_clamped = clamp_hi(wide_t'(cand), wide_t'(rho_max));
        rho_nl      = rho_clamped[DATA_W-1:0];
    end

    always_comb begin
        if (center_amp == D_MIN) begin
            amp_abs = D_MAX;
        end else if (center_amp[DATA_W-1]) begin
            amp_abs = -center_amp;
        end else begin
            amp_abs = center_amp;
        end
        is_quiet  = (amp_abs < quiet_thresh);
        quiet_inc = is_quiet ? quiet_q + 1'b1 : '0;
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        quiet_d    = quiet_q;
        dec_d      = dec_q;
        rho_d      = rho_q;
        iter_d     = iter_q;
        drop_d     = drop_q;
        data_d     = data_q;
        valid_d    = valid_q;
        latch_d    = 1'b0;
        take       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rho_d   = rho_init;
                quiet_d = '0;
                if (strike) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    iter_d     = '0;
                    dec_d      = '0;
                end
            end
            ST_LOAD: begin
                rho_d = rho_init;
                if (strike) begin
                    load_cnt_d = '0;
                    iter_d     = '0;
                    dec_d      = '0;
                end else if (load_cnt_q == LD_LAST) begin
                    state_d    = ST_RUN;
                    load_cnt_d = '0;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (strike) begin
                    state_d    = ST_LOAD;
                    load_cnt_d = '0;
                    iter_d     = '0;
                    dec_d      = '0;
                    quiet_d    = '0;
                    rho_d      = rho_init;
                end else if (iter_done) begin
                    latch_d = 1'b1;
                    if (iter_q != '1) begin
                        iter_d = iter_q + 1'b1;
                    end
                    rho_d = nonlin_en ? rho_nl : rho_init;
                    if (quiet_inc == QT_LIM) begin
                        state_d = ST_IDLE;
                        quiet_d = '0;
                    end else begin
                        quiet_d = quiet_inc;
                    end
                    if (dec_q == DV_LAST) begin
                        dec_d = '0;
                        take  = 1'b1;
                    end else begin
                        dec_d = dec_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A held sample is never overwritten while the consumer is stalling it.
        if (take) begin
            if (!valid_q || sample_ready) begin
                data_d  = center_amp;
                valid_d = 1'b1;
            end else if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            quiet_q    <= '0;
            dec_q      <= '0;
            rho_q      <= '0;
            iter_q     <= '0;
            drop_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            latch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            quiet_q    <= quiet_d;
            dec_q      <= dec_d;
            rho_q      <= rho_d;
            iter_q     <= iter_d;
            drop_q     <= drop_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            latch_q    <= latch_d;
        end
    end

    always_comb begin
        grid_reset     = (state_q == ST_RUN);
        load_hit       = (state_q != ST_RUN);
        busy           = (state_q != ST_IDLE);
        latch_feedback = latch_q;
        rho            = rho_q;
        sample_data    = data_q;
        sample_valid   = valid_q;
        iter_count     = iter_q;
        drop_count     = drop_q;
    end

endmodule

// File: tb/tb_drum_iter_ctrl.sv
// Directed bench for drum_iter_ctrl with a cycle-level reference model and
// literal spot checks of key values.
module tb_drum_iter_ctrl;

    localparam int LC   = 4;
    localparam int SD   = 2;
    localparam int QI   = 4;
    localparam int MAXP = 131071;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        strike = 1'b0;
    logic        nonlin_en = 1'b1;
    logic        iter_done = 1'b0;
    logic        sample_ready = 1'b0;
    logic [17:0] rho_init = 18'h01999;
    logic [17:0] rho_max = 18'h1FFFF;
    logic [17:0] quiet_thresh = 18'h0;
    logic [17:0] center_amp = 18'h0;

    logic        grid_reset, load_hit, latch_feedback, sample_valid, busy;
    logic [17:0] rho, sample_data;
    logic [15:0] iter_count, drop_count;

    drum_iter_ctrl #(
        .DATA_W      (18),
        .FRAC_W      (17),
        .RHO_SHIFT   (5),
        .LOAD_CYCLES (LC),
        .SAMPLE_DIV  (SD),
        .QUIET_ITERS (QI),
        .CNT_W       (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .strike         (strike),
        .nonlin_en      (nonlin_en),
        .rho_init       (rho_init),
        .rho_max        (rho_max),
        .quiet_thresh   (quiet_thresh),
        .iter_done      (iter_done),
        .center_amp     (center_amp),
        .grid_reset     (grid_reset),
        .load_hit       (load_hit),
        .latch_feedback (latch_feedback),
        .rho            (rho),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .busy           (busy),
        .iter_count     (iter_count),
        .drop_count     (drop_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int s18(input logic [17:0] v);
        return v[17] ? int'(v) - 262144 : int'(v);
    endfunction

    function automatic int mag(input int a);
        if (a == -131072) return MAXP;
        return (a < 0) ? -a : a;
    endfunction

    function automatic int exp_rho(input int init, input int mx, input int a);
        longint sq;
        int     cand;
        sq = (longint'(a) * longint'(a)) >>> 17;
        if (sq > MAXP) sq = MAXP;
        cand = init + int'(sq >>> 5);
        return (cand < mx) ? cand : mx;
    endfunction

    // Reference model: mode 0=idle, 1=loading, 2=running.
    int m_mode = 0, m_left = 0, m_rho = 0, m_iter = 0, m_quiet = 0;
    int m_dec = 0, m_drop = 0, m_data = 0, m_amp = 0;
    bit m_valid = 0, m_latch = 0, m_new = 0, m_accept = 0;

    always @(posedge clock) begin
        if (!reset) begin
            m_mode = 0; m_left = 0; m_rho = 0; m_iter = 0; m_quiet = 0;
            m_dec = 0; m_drop = 0; m_data = 0; m_valid = 0; m_latch = 0;
        end else begin
            m_amp    = s18(center_amp);
            m_new    = 0;
            m_latch  = 0;
            m_accept = m_valid && sample_ready;
            if (strike) begin
                m_mode = 1; m_left = LC; m_iter = 0; m_dec = 0; m_quiet = 0;
                m_rho = s18(rho_init);
            end else if (m_mode == 0) begin
                m_rho = s18(rho_init);
            end else if (m_mode == 1) begin
                m_rho = s18(rho_init);
                if (m_left == 1) m_mode = 2;
                else m_left--;
            end else if (iter_done) begin
                m_latch = 1;
                if (m_iter < 65535) m_iter++;
                m_rho = nonlin_en ? exp_rho(s18(rho_init), s18(rho_max), m_amp)
                                  : s18(rho_init);
                m_quiet = (mag(m_amp) < s18(quiet_thresh)) ? m_quiet + 1 : 0;
                if (m_quiet == QI) begin
                    m_mode = 0;
                    m_quiet = 0;
                end
                m_dec++;
                if (m_dec == SD) begin
                    m_dec = 0;
                    m_new = 1;
                end
            end
            if (m_new) begin
                if (!m_valid || sample_ready) begin
                    m_data = m_amp;
                    m_valid = 1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
            end else if (m_accept) begin
                m_valid = 0;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        chk("m_grid_reset", int'(grid_reset), int'(m_mode == 2));
        chk("m_load_hit", int'(load_hit), int'(m_mode != 2));
        chk("m_busy", int'(busy), int'(m_mode != 0));
        chk("m_rho", s18(rho), m_rho);
        chk("m_latch", int'(latch_feedback), int'(m_latch));
        chk("m_iter_count", int'(iter_count), m_iter);
        chk("m_drop_count", int'(drop_count), m_drop);
        chk("m_valid", int'(sample_valid), int'(m_valid));
        chk("m_data", s18(sample_data), m_data);
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic iter(input logic [17:0] amp);
        center_amp = amp;
        iter_done = 1'b1;
        @(negedge clock);
        iter_done = 1'b0;
    endtask

    task automatic pulse_strike();
        strike = 1'b1;
        @(negedge clock);
        strike = 1'b0;
    endtask

    task automatic wait_run();
        for (int i = 0; i < 20 && !grid_reset; i++) cyc();
        chk("reach_run", int'(grid_reset), 1);
    endtask

    initial begin
        #1;
        chk("rst_grid_reset", int'(grid_reset), 0);
        chk("rst_load_hit", int'(load_hit), 1);
        chk("rst_rho", int'(rho), 0);
        chk("rst_valid", int'(sample_valid), 0);
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        cyc();
        chk("idle_rho", int'(rho), 'h01999);

        pulse_strike();
        chk("load_busy", int'(busy), 1);
        chk("load_grid_reset", int'(grid_reset), 0);
        chk("load_rho", int'(rho), 'h01999);
        for (int i = 0; i < LC - 1; i++) begin
            cyc();
            chk("load_hold", int'(grid_reset), 0);
        end
        cyc();
        chk("run_grid_reset", int'(grid_reset), 1);
        chk("run_load_hit", int'(load_hit), 0);

        iter(18'h10000);
        chk("half_rho", int'(rho), 'h01D99);
        chk("half_latch", int'(latch_feedback), 1);
        chk("half_iter", int'(iter_count), 1);
        cyc();
        chk("latch_one_cycle", int'(latch_feedback), 0);

        rho_init = 18'h0F000;
        rho_max  = 18'h0F5C2;
        iter(18'h20000);
        chk("neg1_rho_clamp", int'(rho), 'h0F5C2);
        chk("neg1_sample", int'(sample_data), 'h20000);
        cyc();
        nonlin_en = 1'b0;
        iter(18'h10000);
        chk("linear_rho", int'(rho), 'h0F000);
        sample_ready = 1'b1;
        cyc();
        sample_ready = 1'b0;
        chk("drain_valid", int'(sample_valid), 0);

        nonlin_en = 1'b1;
        rho_init  = 18'h01999;
        rho_max   = 18'h1FFFF;
        pulse_strike();
        chk("restart_rho", int'(rho), 'h01999);
        chk("restart_grid_reset", int'(grid_reset), 0);
        wait_run();
        for (int k = 1; k <= 6; k++) begin
            iter(18'(k * 'h100));
            cyc();
        end
        chk("bp_data", int'(sample_data), 'h00200);
        chk("bp_valid", int'(sample_valid), 1);
        chk("bp_drops", int'(drop_count), 2);
        sample_ready = 1'b1;
        cyc();
        chk("accept_valid", int'(sample_valid), 0);
        chk("accept_data", int'(sample_data), 'h00200);

        quiet_thresh = 18'h00010;
        iter(18'h00008); cyc();
        iter(18'h00008); cyc();
        iter(18'h00100); cyc();
        iter(18'h00008); cyc();
        iter(18'h00008); cyc();
        iter(18'h00008); cyc();
        chk("loud_resets_quiet", int'(busy), 1);
        iter(18'h00008);
        chk("quiet_idle_busy", int'(busy), 0);
        chk("quiet_idle_grid", int'(grid_reset), 0);
        cyc();
        chk("idle_reload_rho", int'(rho), 'h01999);

        pulse_strike();
        wait_run();
        iter(18'h10000); cyc();
        chk("pre_restart_rho", int'(rho), 'h01D99);
        sample_ready = 1'b0;
        iter(18'h00300); cyc();
        iter(18'h00300); cyc();
        chk("pending_valid", int'(sample_valid), 1);
        pulse_strike();
        chk("midrun_rho", int'(rho), 'h01999);
        chk("midrun_busy", int'(busy), 1);
        chk("midrun_grid", int'(grid_reset), 0);
        chk("pending_survives", int'(sample_valid), 1);
        cyc();
        #2 reset = 1'b0;
        #1;
        chk("async_grid_reset", int'(grid_reset), 0);
        chk("async_load_hit", int'(load_hit), 1);
        chk("async_rho", int'(rho), 0);
        chk("async_iter", int'(iter_count), 0);
        chk("async_drop", int'(drop_count), 0);
        chk("async_valid", int'(sample_valid), 0);
        chk("async_data", int'(sample_data), 0);
        chk("async_latch", int'(latch_feedback), 0);
        chk("async_busy", int'(busy), 0);
        cyc();
        reset = 1'b1;
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
